// File: rtl/vram_port_arbiter_pkg.sv
// Shared constants for the VDP/host VRAM arbiter: RAM geometry and FSM state encodings.
package vram_port_arbiter_pkg;

  localparam int RAM_DATA_W = 32;
  localparam int RAM_BE_W   = 4;
  localparam int RAM_DEPTH  = 256;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_ACK     = 2'd2;

  // An all-zero byte-enable field marks a read.
  function automatic logic is_read_op(input logic [RAM_BE_W-1:0] be);
    return ~|be;
  endfunction

endpackage

// File: rtl/vram_port_arbiter_if.sv
// Host-side valid/ready bus into the VRAM arbiter; master = Wishbone host, slave = arbiter.
interface vram_port_arbiter_if
  import vram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) ();

  logic                  host_valid;
  logic [ADDR_WIDTH-1:0] host_address;
  logic [RAM_BE_W-1:0]   host_wstrb;
  logic [RAM_DATA_W-1:0] host_write_data;
  logic [RAM_DATA_W-1:0] host_read_data;
  logic                  host_ready;

  modport master (
    output host_valid, host_address, host_wstrb, host_write_data,
    input  host_read_data, host_ready
  );

  modport slave (
    input  host_valid, host_address, host_wstrb, host_write_data,
    output host_read_data, host_ready
  );

endinterface

// File: rtl/vram_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int WIDTH = 10,
  parameter int LIMIT = 1023
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_limit_o
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != LIM)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign at_limit_o = (count_q == LIM);

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares the single-port tile RAM between the VDP (always wins) and the host, which
// slots into VDP-idle cycles; blocked host cycles feed a sticky starvation flag.
module vram_port_arbiter
  import vram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int STARVE_LIMIT = 1023
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  vdp_req,
  input  logic [ADDR_WIDTH-1:0] vdp_address,
  input  logic [RAM_BE_W-1:0]   vdp_we,
  input  logic [RAM_DATA_W-1:0] vdp_write_data,
  output logic [RAM_DATA_W-1:0] vdp_read_data,
  output logic                  vdp_read_valid,
  vram_port_arbiter_if.slave    host,
  input  logic                  starve_clear,
  output logic                  host_starved,
  output logic                  ram_en,
  output logic [RAM_BE_W-1:0]   ram_we,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [RAM_DATA_W-1:0] ram_write_data,
  input  logic [RAM_DATA_W-1:0] ram_read_data
);

  localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] NEAR  = CNT_W'(STARVE_LIMIT - 1);

  logic [1:0]            state_q, state_d;
  logic                  host_rd_q, host_rd_d;
  logic [RAM_DATA_W-1:0] hrd_q, hrd_d;
  logic                  host_ready_q;
  logic                  vdp_rv_q;
  logic                  starved_q, starved_d;

  logic                  host_issue;
  logic                  cnt_inc, cnt_clr, cnt_at_limit;
  logic [CNT_W-1:0]      cnt_value;

  assign host_issue = (state_q == ST_IDLE) & host.host_valid & ~vdp_req;
  assign cnt_inc    = (state_q == ST_IDLE) & host.host_valid & vdp_req;
  assign cnt_clr    = starve_clear | (state_q == ST_ACK);

  sat_counter #(
    .WIDTH (CNT_W),
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc_i      (cnt_inc),
    .clr_i      (cnt_clr),
    .count_o    (cnt_value),
    .at_limit_o (cnt_at_limit)
  );

  // The VDP owns the port whenever it asks; the host only on its single issue cycle.
  always_comb begin
    ram_en         = 1'b0;
    ram_we         = '0;
    ram_address    = '0;
    ram_write_data = '0;
    if (vdp_req) begin
      ram_en         = 1'b1;
      ram_we         = vdp_we;
      ram_address    = vdp_address;
      ram_write_data = vdp_write_data;
    end else if (host_issue) begin
      ram_en         = 1'b1;
      ram_we         = host.host_wstrb;
      ram_address    = host.host_address;
      ram_write_data = host.host_write_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    host_rd_d = host_rd_q;
    hrd_d     = hrd_q;
    case (state_q)
      ST_IDLE: begin
        if (host_issue) begin
          state_d   = ST_CAPTURE;
          host_rd_d = is_read_op(host.host_wstrb);
        end
      end
      ST_CAPTURE: begin
        // RAM Do still holds the host's data here even if the VDP issues this cycle.
        if (host_rd_q) begin
          hrd_d = ram_read_data;
        end
        state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Flag sets on the same edge the count lands on the limit; a clear in that cycle wins.
  always_comb begin
    if (starve_clear) begin
      starved_d = 1'b0;
    end else begin
      starved_d = starved_q | cnt_at_limit | (cnt_inc & (cnt_value == NEAR));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      host_rd_q    <= 1'b0;
      hrd_q        <= '0;
      host_ready_q <= 1'b0;
      vdp_rv_q     <= 1'b0;
      starved_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      host_rd_q    <= host_rd_d;
      hrd_q        <= hrd_d;
      host_ready_q <= (state_q == ST_CAPTURE);
      vdp_rv_q     <= vdp_req & is_read_op(vdp_we);
      starved_q    <= starved_d;
    end
  end

  assign host.host_ready     = host_ready_q;
  assign host.host_read_data = hrd_q;
  assign vdp_read_valid      = vdp_rv_q;
  assign vdp_read_data       = ram_read_data;
  assign host_starved        = starved_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed + randomized bench for vram_port_arbiter against a transaction-level model.
module tb_vram_port_arbiter;

  localparam int STARVE_LIM = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vdp_req;
  logic [7:0]  vdp_address;
  logic [3:0]  vdp_we;
  logic [31:0] vdp_write_data;
  logic [31:0] vdp_read_data;
  logic        vdp_read_valid;
  logic        starve_clear;
  logic        host_starved;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [7:0]  ram_address;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;

  vram_port_arbiter_if #(.ADDR_WIDTH(8)) hif ();

  vram_port_arbiter #(
    .ADDR_WIDTH   (8),
    .STARVE_LIMIT (STARVE_LIM)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vdp_req        (vdp_req),
    .vdp_address    (vdp_address),
    .vdp_we         (vdp_we),
    .vdp_write_data (vdp_write_data),
    .vdp_read_data  (vdp_read_data),
    .vdp_read_valid (vdp_read_valid),
    .host           (hif),
    .starve_clear   (starve_clear),
    .host_starved   (host_starved),
    .ram_en         (ram_en),
    .ram_we         (ram_we),
    .ram_address    (ram_address),
    .ram_write_data (ram_write_data),
    .ram_read_data  (ram_read_data)
  );

  always #5 clk = ~clk;

  // Single-port byte-writable RAM with one cycle of read latency.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_address][8*b +: 8] <= ram_write_data[8*b +: 8];
      if (ram_we == 4'd0) ram_read_data <= mem[ram_address];
    end
  end

  // Reference model state
  logic [31:0] shadow [256];
  int          cyc, issue_cyc, blocked;
  bit          host_rd_op, exp_starved, vrd_pend;
  logic [31:0] host_rd_val, exp_hrd, vrd_exp;
  int          n_chk, n_fail;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    issue_cyc   = -1;
    blocked     = 0;
    exp_starved = 0;
    exp_hrd     = '0;
    vrd_pend    = 0;
    host_rd_op  = 0;
    host_rd_val = '0;
  endtask

  task automatic drive_vdp(input bit req, input logic [7:0] a, input bit wr);
    vdp_req        = req;
    vdp_address    = req ? a : 8'd0;
    vdp_we         = (req && wr) ? 4'($urandom_range(1, 15)) : 4'd0;
    vdp_write_data = $urandom;
  endtask

  // Inputs are already driven; check this cycle against the model, then advance it.
  task automatic run_cycle(output bit rdy);
    bit issue_now, blocked_now, ready_now;
    @(negedge clk);
    issue_now   = hif.host_valid && (issue_cyc < 0) && !vdp_req;
    blocked_now = hif.host_valid && (issue_cyc < 0) && vdp_req;
    ready_now   = (issue_cyc >= 0) && (cyc == issue_cyc + 2);
    if (ready_now && host_rd_op) exp_hrd = host_rd_val;

    if (vdp_req) begin
      chk("ram_en_vdp", 32'(ram_en), 32'd1);
      chk("ram_we_vdp", 32'(ram_we), 32'(vdp_we));
      chk("ram_addr_vdp", 32'(ram_address), 32'(vdp_address));
      chk("ram_wdata_vdp", ram_write_data, vdp_write_data);
    end else if (issue_now) begin
      chk("ram_en_host", 32'(ram_en), 32'd1);
      chk("ram_we_host", 32'(ram_we), 32'(hif.host_wstrb));
      chk("ram_addr_host", 32'(ram_address), 32'(hif.host_address));
      chk("ram_wdata_host", ram_write_data, hif.host_write_data);
    end else begin
      chk("ram_en_idle", 32'(ram_en), 32'd0);
      chk("ram_we_idle", 32'(ram_we), 32'd0);
      chk("ram_addr_idle", 32'(ram_address), 32'd0);
      chk("ram_wdata_idle", ram_write_data, 32'd0);
    end
    chk("host_ready", 32'(hif.host_ready), 32'(ready_now));
    chk("host_read_data", hif.host_read_data, exp_hrd);
    chk("vdp_read_valid", 32'(vdp_read_valid), 32'(vrd_pend));
    if (vrd_pend) chk("vdp_read_data", vdp_read_data, vrd_exp);
    chk("host_starved", 32'(host_starved), 32'(exp_starved));

    vrd_pend = vdp_req && (vdp_we == 4'd0);
    if (vrd_pend) vrd_exp = shadow[vdp_address];
    if (vdp_req) shadow[vdp_address] = merge(shadow[vdp_address], vdp_write_data, vdp_we);
    if (issue_now) begin
      issue_cyc   = cyc;
      host_rd_op  = (hif.host_wstrb == 4'd0);
      host_rd_val = shadow[hif.host_address];
      shadow[hif.host_address] = merge(shadow[hif.host_address], hif.host_write_data,
                                       hif.host_wstrb);
    end
    if (starve_clear) begin
      blocked     = 0;
      exp_starved = 0;
    end else if (ready_now) begin
      blocked = 0;
    end else if (blocked_now) begin
      if (blocked < STARVE_LIM) blocked++;
      if (blocked == STARVE_LIM) exp_starved = 1;
    end
    if (ready_now) issue_cyc = -1;
    rdy = ready_now;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // One host transaction: VDP busy for the first `busy` cycles, optional VDP read on
  // the capture cycle, or random VDP/clear traffic when rnd is set.
  task automatic host_txn(input logic [7:0] a, input logic [3:0] s, input logic [31:0] d,
                          input int busy, input int cap_vdp, input bit rnd, output int lat);
    bit done;
    done = 0;
    lat  = 0;
    hif.host_valid      = 1'b1;
    hif.host_address    = a;
    hif.host_wstrb      = s;
    hif.host_write_data = d;
    for (int i = 0; i < 300 && !done; i++) begin
      if (i < busy)
        drive_vdp(1, 8'($urandom), 1'($urandom));
      else if (rnd)
        drive_vdp($urandom_range(0, 2) == 0, 8'($urandom), 1'($urandom));
      else if (cap_vdp >= 0 && i == busy + 1)
        drive_vdp(1, 8'(cap_vdp), 0);
      else
        drive_vdp(0, 8'd0, 0);
      starve_clear = rnd ? ($urandom_range(0, 15) == 0) : 1'b0;
      run_cycle(done);
      lat++;
    end
    if (!done) chk("host_timeout", 32'd0, 32'd1);
    hif.host_valid = 1'b0;
    starve_clear   = 1'b0;
    drive_vdp(0, 8'd0, 0);
  endtask

  task automatic idle_cycle(input bit clr);
    bit r;
    hif.host_valid = 1'b0;
    drive_vdp(0, 8'd0, 0);
    starve_clear = clr;
    run_cycle(r);
    starve_clear = 1'b0;
  endtask

  initial begin
    int lat;
    bit r;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    model_reset();
    reset_n             = 1'b0;
    hif.host_valid      = 1'b0;
    hif.host_address    = '0;
    hif.host_wstrb      = '0;
    hif.host_write_data = '0;
    starve_clear        = 1'b0;
    drive_vdp(0, 8'd0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_host_ready", 32'(hif.host_ready), 32'd0);
    chk("reset_vdp_rv", 32'(vdp_read_valid), 32'd0);
    chk("reset_hrd", hif.host_read_data, 32'd0);
    chk("reset_starved", 32'(host_starved), 32'd0);
    chk("reset_ram_en", 32'(ram_en), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill the RAM through the VDP port.
    for (int i = 0; i < 256; i++) begin
      vdp_req        = 1'b1;
      vdp_address    = 8'(i);
      vdp_we         = 4'hF;
      vdp_write_data = (i == 8'h12) ? 32'hDEADBEEF : $urandom;
      run_cycle(r);
    end
    idle_cycle(0);

    host_txn(8'h12, 4'd0, 32'd0, 0, -1, 0, lat);
    chk("read_latency", 32'(lat), 32'd3);
    chk("read_deadbeef", hif.host_read_data, 32'hDEADBEEF);

    host_txn(8'h05, 4'b0011, 32'h0000ABCD, 0, -1, 0, lat);
    chk("write_latency", 32'(lat), 32'd3);
    drive_vdp(1, 8'h05, 0);
    run_cycle(r);
    idle_cycle(0);
    chk("vdp_rd_after_host_wr", 32'(vdp_read_data[15:0]), 32'h0000ABCD);

    host_txn(8'h21, 4'd0, 32'd0, 10, -1, 0, lat);
    chk("busy10_latency", 32'(lat), 32'd13);
    chk("busy10_not_starved", 32'(host_starved), 32'd0);

    host_txn(8'h30, 4'd0, 32'd0, 0, 8'h31, 0, lat);
    chk("capture_hrd", hif.host_read_data, shadow[8'h30]);
    idle_cycle(0);

    host_txn(8'h40, 4'hF, 32'h1234_5678, 20, -1, 0, lat);
    chk("starve_sticky", 32'(host_starved), 32'd1);
    idle_cycle(1);
    chk("starve_cleared", 32'(host_starved), 32'd0);

    // Aborted request keeps its blocked count: 5 + 11 reaches the limit.
    hif.host_valid   = 1'b1;
    hif.host_address = 8'h50;
    hif.host_wstrb   = 4'd0;
    for (int i = 0; i < 5; i++) begin
      drive_vdp(1, 8'($urandom), 0);
      run_cycle(r);
    end
    hif.host_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_vdp($urandom_range(0, 1) == 1, 8'($urandom), 0);
      run_cycle(r);
    end
    host_txn(8'h50, 4'd0, 32'd0, 11, -1, 0, lat);
    chk("abort_count_held", 32'(host_starved), 32'd1);
    idle_cycle(1);

    for (int t = 0; t < 150; t++) begin
      host_txn(8'($urandom), ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0,
               $urandom, $urandom_range(0, 3), -1, 1, lat);
    end
    idle_cycle(0);

    // Reset asserted during the capture cycle of a host read.
    hif.host_valid   = 1'b1;
    hif.host_address = 8'h12;
    hif.host_wstrb   = 4'd0;
    drive_vdp(0, 8'd0, 0);
    run_cycle(r);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(hif.host_ready), 32'd0);
    chk("midrst_hrd", hif.host_read_data, 32'd0);
    chk("midrst_starved", 32'(host_starved), 32'd0);
    hif.host_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_ready_hold", 32'(hif.host_ready), 32'd0);
      chk("midrst_ram_en", 32'(ram_en), 32'd0);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    idle_cycle(0);
    host_txn(8'h12, 4'd0, 32'd0, 0, -1, 0, lat);
    chk("post_reset_latency", 32'(lat), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
